wb_demux_regs: RTL

- Write-back end of the operand path: takes 8-bit ALU results and routes (demultiplexes) each one into one of NREGS operand registers.
- Its registered read ports supply the d0/d1 inputs of the B-operand mux, closing the loop from ALU output back to the operand select.
- A one-entry pending-write buffer and a valid/ready handshake let the CPU stall commits with hold.

---
 rtl/wb_demux_regs_pkg.sv | 19 +
 rtl/wb_demux_regs_regfile.sv | 45 ++++
 rtl/wb_demux_regs.sv | 103 ++++++++++
 3 files changed

// File: rtl/wb_demux_regs_pkg.sv
// Shared operand-path definitions: data width, register indices and the
// encoding of the one-entry pending-write buffer.
package wb_demux_regs_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int IDX_W     = 2;
    localparam int NREGS_DEF = 4;

    localparam logic [IDX_W-1:0] REG_A = 2'd0;
    localparam logic [IDX_W-1:0] REG_B = 2'd1;
    localparam logic [IDX_W-1:0] REG_C = 2'd2;
    localparam logic [IDX_W-1:0] REG_D = 2'd3;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/wb_demux_regs_regfile.sv
// Operand register storage: one write port and two registered read ports.
// A read of the register being written in the same cycle returns the new
// value, so a commit is visible on d0/d1 at the same edge it lands.
module wb_demux_regs_regfile
    import wb_demux_regs_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_sel0,
    input  logic [IDX_W-1:0] rd_sel1,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1
);

    logic [WIDTH-1:0] regs_r [NREGS];
    logic [WIDTH-1:0] d0_r;
    logic [WIDTH-1:0] d1_r;

    // Storage write and write-first registered reads; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
            d0_r <= {WIDTH{1'b0}};
            d1_r <= {WIDTH{1'b0}};
        end else begin
            if (wr_en) begin
                regs_r[wr_idx] <= wr_data;
            end
            d0_r <= (wr_en && (wr_idx == rd_sel0)) ? wr_data : regs_r[rd_sel0];
            d1_r <= (wr_en && (wr_idx == rd_sel1)) ? wr_data : regs_r[rd_sel1];
        end
    end

    assign d0 = d0_r;
    assign d1 = d1_r;

endmodule

// File: rtl/wb_demux_regs.sv
// Write-back demux: accepts ALU results through a valid/ready handshake into a
// one-entry pending buffer, commits them to the operand registers unless the
// CPU holds, and counts committed writes.
module wb_demux_regs
    import wb_demux_regs_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [IDX_W-1:0] wb_dest,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             hold,
    input  logic [IDX_W-1:0] rd_sel0,
    input  logic [IDX_W-1:0] rd_sel1,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic             pend,
    output logic [7:0]       wr_count
);

    buf_state_e       state_r;
    logic [IDX_W-1:0] buf_dest_r;
    logic [WIDTH-1:0] buf_data_r;
    logic [7:0]       wr_count_r;
    logic             commit_s;
    logic             ready_s;
    logic             accept_s;

    // Handshake decode: the buffer drains when not held, and a new result is
    // taken whenever the buffer is empty or draining in this same cycle.
    always_comb begin
        commit_s = 1'b0;
        ready_s  = 1'b0;
        if (state_r == BUF_FULL) begin
            commit_s = ~hold;
        end else begin
            commit_s = 1'b0;
        end
        if (reset) begin
            ready_s = 1'b0;
        end else begin
            ready_s = (state_r == BUF_EMPTY) || commit_s;
        end
        accept_s = wb_valid && ready_s;
    end

    // Pending-buffer FSM, buffer capture and committed-write counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= BUF_EMPTY;
            buf_dest_r <= REG_A;
            buf_data_r <= {WIDTH{1'b0}};
            wr_count_r <= 8'd0;
        end else begin
            if (accept_s) begin
                buf_dest_r <= wb_dest;
                buf_data_r <= wb_data;
            end
            if (commit_s) begin
                wr_count_r <= wr_count_r + 8'd1;
            end
            case (state_r)
                BUF_EMPTY: begin
                    if (accept_s) begin
                        state_r <= BUF_FULL;
                    end
                end
                BUF_FULL: begin
                    if (commit_s && !accept_s) begin
                        state_r <= BUF_EMPTY;
                    end
                end
                default: begin
                    state_r <= BUF_EMPTY;
                end
            endcase
        end
    end

    wb_demux_regs_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (commit_s),
        .wr_idx  (buf_dest_r),
        .wr_data (buf_data_r),
        .rd_sel0 (rd_sel0),
        .rd_sel1 (rd_sel1),
        .d0      (d0),
        .d1      (d1)
    );

    assign wb_ready = ready_s;
    assign pend     = (state_r == BUF_FULL);
    assign wr_count = wr_count_r;

endmodule
